// File: rtl/tt_um_hoene_manchester_rx.sv
// rtl/tt_um_hoene_manchester_rx.sv - Manchester receiver with rate acquisition, drift tracking and word framing
module tt_um_hoene_manchester_rx #(
  parameter int CNT_W    = 6,
  parameter int MIN_HALF = 4,
  parameter int WORD_W   = 8,
  parameter int POLARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  output logic              out_data,
  output logic              out_valid,
  output logic              out_error,
  output logic              out_locked,
  output logic [CNT_W-1:0]  out_halfperiod,
  output logic [WORD_W-1:0] out_word,
  output logic              out_word_valid
);

  typedef enum logic {HUNT, LOCKED} state_t;
  typedef enum logic {MID, BOUNDARY} phase_t;

  localparam int XW = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_HALF);
  localparam logic [XW-1:0]    MIN_X      = XW'(MIN_HALF);
  localparam logic [XW-1:0]    LOCK_MIN_X = XW'(2 * MIN_HALF);
  localparam logic [XW-1:0]    MAX_X      = XW'(CNT_MAX);
  localparam logic [5:0]       LAST_BIT   = 6'(WORD_W - 1);
  localparam logic             POL        = (POLARITY != 0);

  logic in_r, in_rr, trans;
  logic [CNT_W-1:0] cnt, w, half, half_n, prev_w, prev_w_n;
  logic [CNT_W-1:0] half_short, half_long;
  logic [XW-1:0] w_x, half_x, prev_x, two_w, three_half, five_half, avg_short, avg_long;
  logic is_glitch, is_short, is_long, lock_ok, idle_hit, bit_val;
  logic started, started_n, prev_valid, prev_valid_n, emit, err;
  state_t state, state_n;
  phase_t phase, phase_n;

  logic valid_s, error_s, data_s, locked_s, word_valid_s;
  logic [WORD_W-1:0] word_s, shreg_n;
  logic [WORD_W-2:0] shreg;
  logic [5:0] bit_cnt;

  // Interval measurement: w counts cycles since the previous edge, saturating at the counter limit.
  assign trans      = in_r ^ in_rr;
  assign w          = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  assign w_x        = {3'b000, w};
  assign half_x     = {3'b000, half};
  assign prev_x     = {3'b000, prev_w};
  assign two_w      = w_x << 1;
  assign three_half = (half_x << 1) + half_x;
  assign five_half  = (half_x << 2) + half_x;

  assign is_glitch = w_x < MIN_X;
  assign is_short  = !is_glitch && (two_w < three_half);
  assign is_long   = !is_glitch && !is_short && (two_w < five_half);
  // A long interval following a short one marks the opposite bit after two equal bits.
  assign lock_ok   = prev_valid && (w_x >= LOCK_MIN_X) && (w_x < MAX_X) &&
                     ((prev_x << 2) <= ((w_x << 1) + w_x));
  assign idle_hit  = !trans && (two_w >= five_half);

  // Slow first-order tracking; a long interval contributes its half-length.
  assign avg_short  = (three_half + w_x) >> 2;
  assign avg_long   = (three_half + (w_x >> 1)) >> 2;
  assign half_short = (avg_short < MIN_X) ? MIN_C : avg_short[CNT_W-1:0];
  assign half_long  = (avg_long < MIN_X) ? MIN_C : avg_long[CNT_W-1:0];

  assign bit_val = in_r ^ POL;
  assign shreg_n = {shreg, bit_val};

  // Next-state decode: acquisition in HUNT, interval classification and tracking in LOCKED.
  always_comb begin
    state_n      = state;
    phase_n      = phase;
    half_n       = half;
    prev_w_n     = prev_w;
    prev_valid_n = prev_valid;
    started_n    = started;
    emit         = 1'b0;
    err          = 1'b0;
    case (state)
      HUNT: begin
        if (trans) begin
          if (!started) begin
            started_n    = 1'b1;
            prev_valid_n = 1'b0;
          end else if (is_glitch) begin
            prev_valid_n = 1'b0;
          end else begin
            prev_w_n     = w;
            prev_valid_n = 1'b1;
            if (lock_ok) begin
              state_n = LOCKED;
              half_n  = w >> 1;
              phase_n = MID;
              emit    = 1'b1;
            end
          end
        end
      end
      default: begin
        if (trans) begin
          if (is_short && phase == MID) begin
            phase_n = BOUNDARY;
            half_n  = half_short;
          end else if (is_short) begin
            phase_n = MID;
            half_n  = half_short;
            emit    = 1'b1;
          end else if (is_long && phase == MID) begin
            half_n  = half_long;
            emit    = 1'b1;
          end else begin
            err = 1'b1;
          end
        end else if (idle_hit) begin
          err = 1'b1;
        end
        if (err) begin
          state_n      = HUNT;
          started_n    = 1'b0;
          prev_valid_n = 1'b0;
        end
      end
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      phase      <= MID;
      half       <= '0;
      prev_w     <= '0;
      prev_valid <= 1'b0;
      started    <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      half       <= half_n;
      prev_w     <= prev_w_n;
      prev_valid <= prev_valid_n;
      started    <= started_n;
    end
  end

  // Input edge pipeline and saturating interval counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_r  <= 1'b0;
      in_rr <= 1'b0;
      cnt   <= '0;
    end else begin
      in_r  <= in;
      in_rr <= in_r;
      if (trans)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  // Bit strobes and word assembly; an error drops the partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_s      <= 1'b0;
      error_s      <= 1'b0;
      data_s       <= 1'b0;
      locked_s     <= 1'b0;
      word_s       <= '0;
      word_valid_s <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
    end else begin
      valid_s      <= emit;
      error_s      <= err;
      locked_s     <= (state_n == LOCKED);
      word_valid_s <= 1'b0;
      if (emit)
        data_s <= bit_val;
      if (err) begin
        bit_cnt <= '0;
      end else if (emit) begin
        shreg <= shreg_n[WORD_W-2:0];
        if (bit_cnt == LAST_BIT) begin
          word_s       <= shreg_n;
          word_valid_s <= 1'b1;
          bit_cnt      <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Output register stage; every output moves together so strobes and levels stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data       <= 1'b0;
      out_valid      <= 1'b0;
      out_error      <= 1'b0;
      out_locked     <= 1'b0;
      out_halfperiod <= '0;
      out_word       <= '0;
      out_word_valid <= 1'b0;
    end else begin
      out_data       <= data_s;
      out_valid      <= valid_s;
      out_error      <= error_s;
      out_locked     <= locked_s;
      out_halfperiod <= half;
      out_word       <= word_s;
      out_word_valid <= word_valid_s;
    end
  end

endmodule

// File: tb/tb_tt_um_hoene_manchester_rx.sv
// tb/tb_tt_um_hoene_manchester_rx.sv - directed bench for the Manchester receiver (both polarities)
module tb_tt_um_hoene_manchester_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_line = 1'b0;

  logic       d0_data, d0_valid, d0_error, d0_locked, d0_word_valid;
  logic [5:0] d0_half;
  logic [7:0] d0_word;
  logic       d1_data, d1_valid, d1_error, d1_locked, d1_word_valid;
  logic [5:0] d1_half;
  logic [7:0] d1_word;

  tt_um_hoene_manchester_rx #(.CNT_W(6), .MIN_HALF(4), .WORD_W(8), .POLARITY(0)) dut0 (
    .clk(clk), .rst(rst), .in(in_line),
    .out_data(d0_data), .out_valid(d0_valid), .out_error(d0_error), .out_locked(d0_locked),
    .out_halfperiod(d0_half), .out_word(d0_word), .out_word_valid(d0_word_valid)
  );

  tt_um_hoene_manchester_rx #(.CNT_W(6), .MIN_HALF(4), .WORD_W(8), .POLARITY(1)) dut1 (
    .clk(clk), .rst(rst), .in(in_line),
    .out_data(d1_data), .out_valid(d1_valid), .out_error(d1_error), .out_locked(d1_locked),
    .out_halfperiod(d1_half), .out_word(d1_word), .out_word_valid(d1_word_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic bit_q[$];
  logic [7:0] word_q[$];
  logic [7:0] word1_q[$];
  int err_cnt = 0;
  int err_cyc = 0;
  int wv_bad = 0;

  always @(negedge clk) begin
    if (d0_valid) bit_q.push_back(d0_data);
    if (d0_word_valid) begin
      word_q.push_back(d0_word);
      if (!d0_valid) wv_bad++;
    end
    if (d1_word_valid) word1_q.push_back(d1_word);
    if (d0_error) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  int n_vec = 0;
  int n_mis = 0;
  int last_change = 0;
  int bit_base, word_base, word1_base, err_base;

  typedef struct {
    int         h;
    logic [7:0] data;
    logic [7:0] word0;
    logic [7:0] word1;
    int         half;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lvl);
    if (lvl !== in_line) last_change = cyc;
    in_line = lvl;
  endtask

  task automatic hold(input logic lvl, input int n);
    drive(lvl);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int h);
    if (b) begin
      hold(1'b0, h);
      hold(1'b1, h);
    end else begin
      hold(1'b1, h);
      hold(1'b0, h);
    end
  endtask

  task automatic send_bits(input logic [31:0] data, input int nb, input int h);
    for (int i = nb - 1; i >= 0; i--) send_bit(data[i], h);
  endtask

  task automatic preamble(input int h);
    send_bit(1'b0, h);
    send_bit(1'b0, h);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    bit_base   = bit_q.size();
    word_base  = word_q.size();
    word1_base = word1_q.size();
    err_base   = err_cnt;
  endtask

  task automatic get_bits(input int base, input int n, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < n; i++)
      v = {v[30:0], (bit_q.size() > base + i) ? bit_q[base + i] : 1'b0};
  endtask

  function automatic logic [31:0] word_at(input int idx);
    return (word_q.size() > idx) ? 32'(word_q[idx]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] word1_at(input int idx);
    return (word1_q.size() > idx) ? 32'(word1_q[idx]) : 32'hDEAD;
  endfunction

  logic [31:0] bits_v;
  int chg;
  logic [7:0] drift_words[6];

  initial begin
    vecs[0] = '{h: 8,  data: 8'hA5, word0: 8'hA5, word1: 8'h5A, half: 8};
    vecs[1] = '{h: 4,  data: 8'hC3, word0: 8'hC3, word1: 8'h3C, half: 4};
    vecs[2] = '{h: 12, data: 8'h81, word0: 8'h81, word1: 8'h7E, half: 12};
    vecs[3] = '{h: 7,  data: 8'hFF, word0: 8'hFF, word1: 8'h00, half: 7};
    vecs[4] = '{h: 20, data: 8'hB6, word0: 8'hB6, word1: 8'h49, half: 20};
    vecs[5] = '{h: 5,  data: 8'h9E, word0: 8'h9E, word1: 8'h61, half: 5};

    // reset held with the line toggling
    repeat (3) begin
      @(posedge clk);
      #1;
      in_line = ~in_line;
    end
    @(negedge clk);
    check("rst_data",   32'(d0_data), 0);
    check("rst_valid",  32'(d0_valid), 0);
    check("rst_error",  32'(d0_error), 0);
    check("rst_locked", 32'(d0_locked), 0);
    check("rst_half",   32'(d0_half), 0);
    check("rst_word",   32'(d0_word), 0);
    check("rst_wvalid", 32'(d0_word_valid), 0);
    @(posedge clk);
    #1;

    // lock + one word per record, both polarities
    foreach (vecs[i]) begin
      do_reset();
      mark();
      preamble(vecs[i].h);
      send_bits(32'(vecs[i].data), 8, vecs[i].h);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_nwords", i), 32'(word_q.size() - word_base), 1);
      check($sformatf("v%0d_word0", i), word_at(word_base), 32'(vecs[i].word0));
      check($sformatf("v%0d_word1", i), word1_at(word1_base), 32'(vecs[i].word1));
      check($sformatf("v%0d_half", i), 32'(d0_half), 32'(vecs[i].half));
      check($sformatf("v%0d_locked", i), 32'(d0_locked), 1);
      check($sformatf("v%0d_errors", i), 32'(err_cnt - err_base), 0);
      check($sformatf("v%0d_nbits", i), 32'(bit_q.size() - bit_base), 8);
    end

    // idle timeout after three bits at H=8
    do_reset();
    mark();
    preamble(8);
    send_bits(32'b101, 3, 8);
    chg = last_change;
    repeat (40) @(posedge clk);
    #1;
    get_bits(bit_base, 3, bits_v);
    check("to_nbits", 32'(bit_q.size() - bit_base), 3);
    check("to_bits", bits_v, 32'b101);
    check("to_errors", 32'(err_cnt - err_base), 1);
    check("to_latency", 32'(err_cyc - chg), 23);
    check("to_nwords", 32'(word_q.size() - word_base), 0);
    check("to_locked", 32'(d0_locked), 0);

    // glitch mid-word, then relock on a fresh preamble
    do_reset();
    mark();
    preamble(8);
    send_bits(32'hA5, 8, 8);
    send_bit(1'b1, 8);
    hold(1'b0, 3);
    hold(1'b1, 2);
    hold(1'b0, 3);
    check("gl_errors", 32'(err_cnt - err_base), 1);
    check("gl_locked", 32'(d0_locked), 0);
    check("gl_nwords", 32'(word_q.size() - word_base), 1);
    hold(1'b1, 8);
    hold(1'b0, 80);
    preamble(8);
    send_bits(32'hC3, 8, 8);
    @(posedge clk);
    #1;
    check("gl_nwords2", 32'(word_q.size() - word_base), 2);
    check("gl_word_a", word_at(word_base), 32'hA5);
    check("gl_word_b", word_at(word_base + 1), 32'hC3);
    check("gl_errors2", 32'(err_cnt - err_base), 1);
    check("gl_relocked", 32'(d0_locked), 1);
    check("gl_nbits", 32'(bit_q.size() - bit_base), 17);

    // rate drift: 8 -> 9 -> 7
    drift_words = '{8'hA5, 8'h3C, 8'h96, 8'hF0, 8'h0F, 8'h69};
    do_reset();
    mark();
    preamble(8);
    send_bits(32'hA53C, 16, 8);
    send_bits(32'h96F0, 16, 9);
    check("dr_half9", 32'(d0_half), 8);
    send_bits(32'h0F69, 16, 7);
    @(posedge clk);
    #1;
    check("dr_nwords", 32'(word_q.size() - word_base), 6);
    foreach (drift_words[i])
      check($sformatf("dr_word%0d", i), word_at(word_base + i), 32'(drift_words[i]));
    check("dr_errors", 32'(err_cnt - err_base), 0);
    check("dr_half7", 32'(d0_half), 7);
    check("dr_locked", 32'(d0_locked), 1);

    // reset in the middle of a word
    do_reset();
    preamble(8);
    send_bits(32'b1010, 4, 8);
    rst = 1'b1;
    mark();
    drive(1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("mr_nbits", 32'(bit_q.size() - bit_base), 0);
    check("mr_nwords", 32'(word_q.size() - word_base), 0);
    check("mr_errors", 32'(err_cnt - err_base), 0);
    check("mr_locked", 32'(d0_locked), 0);
    check("mr_half", 32'(d0_half), 0);

    check("word_valid_alone", 32'(wv_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
